// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit/receive path.
// frame_cycles() gives the clk cycles one complete frame occupies on the line.
package uart_pkg;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;

   localparam int DEF_CLKS_PER_BIT = 16;
   localparam int DEF_DATA_BITS    = 8;
   localparam int DEF_PARITY_EN    = 0;
   localparam int DEF_PARITY_ODD   = 0;
   localparam int DEF_STOP_BITS    = 1;

   function automatic int frame_cycles(input int clks_per_bit, input int data_bits,
                                       input int parity_en, input int stop_bits);
      return (1 + data_bits + parity_en + stop_bits) * clks_per_bit;
   endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled and flags the last cycle.
// Shared by the transmitter and the loopback receiver.
module uart_baud_gen
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic bit_end
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] cnt_q;

   assign bit_end = enable && (cnt_q == LAST);

   // Wrapping on bit_end restarts the count for whatever bit follows.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (clear) begin
         cnt_q <= '0;
      end else if (enable) begin
         cnt_q <= bit_end ? '0 : cnt_q + CW'(1);
      end
   end

endmodule

// File: rtl/uart_tx_core.sv
// UART transmitter: one trigger sends start, DATA_BITS data bits LSB-first,
// optional parity and STOP_BITS stop bits. All outputs come straight from flops.
module uart_tx_core
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
   parameter int DATA_BITS    = DEF_DATA_BITS,
   parameter int PARITY_EN    = DEF_PARITY_EN,
   parameter int PARITY_ODD   = DEF_PARITY_ODD,
   parameter int STOP_BITS    = DEF_STOP_BITS
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] tx_din,
   input  logic       tx_trigger,
   output logic       tx_busy,
   output logic       tx_done,
   output logic       tx_serial
);

   localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
   localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);
   localparam logic [7:0] DATA_MASK = 8'((1 << DATA_BITS) - 1);
   localparam logic       ODD_BIT   = (PARITY_ODD != 0);
   localparam logic       HAS_PAR   = (PARITY_EN != 0);

   tx_state_t  state_q, state_d;
   logic [7:0] shreg_q, shreg_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic       parity_q, parity_d;
   logic       serial_q, serial_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       bit_end;

   // The timer is held clear in IDLE, so START always begins from count 0.
   uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (state_q == IDLE),
      .enable  (state_q != IDLE),
      .bit_end (bit_end)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         shreg_q   <= '0;
         bit_cnt_q <= '0;
         parity_q  <= 1'b0;
         serial_q  <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         shreg_q   <= shreg_d;
         bit_cnt_q <= bit_cnt_d;
         parity_q  <= parity_d;
         serial_q  <= serial_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   // Next-state logic decides the line level of the upcoming bit, so tx_serial
   // changes on the same edge as the state.
   always_comb begin
      state_d   = state_q;
      shreg_d   = shreg_q;
      bit_cnt_d = bit_cnt_q;
      parity_d  = parity_q;
      serial_d  = serial_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (tx_trigger) begin
               shreg_d   = tx_din & DATA_MASK;
               parity_d  = (^(tx_din & DATA_MASK)) ^ ODD_BIT;
               bit_cnt_d = '0;
               state_d   = START;
               serial_d  = 1'b0;
               busy_d    = 1'b1;
            end
         end
         START: begin
            if (bit_end) begin
               state_d   = DATA;
               serial_d  = shreg_q[0];
               bit_cnt_d = '0;
            end
         end
         DATA: begin
            if (bit_end) begin
               if (bit_cnt_q == LAST_DATA) begin
                  bit_cnt_d = '0;
                  if (HAS_PAR) begin
                     state_d  = PARITY;
                     serial_d = parity_q;
                  end else begin
                     state_d  = STOP;
                     serial_d = 1'b1;
                  end
               end else begin
                  shreg_d   = shreg_q >> 1;
                  serial_d  = shreg_q[1];
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end
            end
         end
         PARITY: begin
            if (bit_end) begin
               state_d   = STOP;
               serial_d  = 1'b1;
               bit_cnt_d = '0;
            end
         end
         STOP: begin
            if (bit_end) begin
               if (bit_cnt_q == LAST_STOP) begin
                  state_d   = IDLE;
                  busy_d    = 1'b0;
                  done_d    = 1'b1;
                  serial_d  = 1'b1;
                  bit_cnt_d = '0;
               end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end
            end
         end
         default: begin
            state_d  = IDLE;
            serial_d = 1'b1;
            busy_d   = 1'b0;
         end
      endcase
   end

   assign tx_serial = serial_q;
   assign tx_busy   = busy_q;
   assign tx_done   = done_q;

endmodule

// File: tb/tb_uart_tx_core.sv
// Directed bench for uart_tx_core: four instances cover the default, odd/even
// parity and short (7 data bits, 2 stop bits, 4 clks/bit) configurations.
module tb_uart_tx_core;

   logic       clk;
   logic       rst_n;
   logic [7:0] tx_din;
   logic       trig;
   logic [1:0] sel;
   logic [3:0] trig_v, ser_v, busy_v, done_v;

   int checks = 0;
   int errors = 0;

   logic cap_ser  [0:511];
   logic cap_busy [0:511];
   logic cap_done [0:511];
   int   busy_cnt, done_cnt, first_done;
   logic exp_q [$];

   assign trig_v = trig ? (4'b0001 << sel) : 4'b0000;

   uart_tx_core u_def (
      .clk(clk), .rst_n(rst_n), .tx_din(tx_din), .tx_trigger(trig_v[0]),
      .tx_busy(busy_v[0]), .tx_done(done_v[0]), .tx_serial(ser_v[0]));

   uart_tx_core #(.PARITY_EN(1), .PARITY_ODD(1)) u_odd (
      .clk(clk), .rst_n(rst_n), .tx_din(tx_din), .tx_trigger(trig_v[1]),
      .tx_busy(busy_v[1]), .tx_done(done_v[1]), .tx_serial(ser_v[1]));

   uart_tx_core #(.PARITY_EN(1), .PARITY_ODD(0)) u_even (
      .clk(clk), .rst_n(rst_n), .tx_din(tx_din), .tx_trigger(trig_v[2]),
      .tx_busy(busy_v[2]), .tx_done(done_v[2]), .tx_serial(ser_v[2]));

   uart_tx_core #(.CLKS_PER_BIT(4), .DATA_BITS(7), .STOP_BITS(2)) u_short (
      .clk(clk), .rst_n(rst_n), .tx_din(tx_din), .tx_trigger(trig_v[3]),
      .tx_busy(busy_v[3]), .tx_done(done_v[3]), .tx_serial(ser_v[3]));

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_bit(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic check_int(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // driver: raise trigger for one posedge on the selected instance
   task automatic start_frame(input logic [1:0] s, input logic [7:0] din);
      @(negedge clk);
      sel    = s;
      tx_din = din;
      trig   = 1'b1;
   endtask

   // Sample n negedges; sample 0 is the cycle after the accepting edge.
   // Optional extra trigger pulses at indices t1/t2, and a retrigger on the first tx_done.
   task automatic capture(input int n, input int t1, input int t2, input logic [7:0] tdin,
                          input bit on_done, input logic [7:0] ddin);
      busy_cnt   = 0;
      done_cnt   = 0;
      first_done = -1;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         trig        = 1'b0;
         cap_ser[i]  = ser_v[sel];
         cap_busy[i] = busy_v[sel];
         cap_done[i] = done_v[sel];
         if (cap_busy[i]) busy_cnt++;
         if (cap_done[i]) begin
            done_cnt++;
            if (first_done < 0) first_done = i;
         end
         if (i == t1 || i == t2) begin
            tx_din = tdin;
            trig   = 1'b1;
         end
         if (on_done && cap_done[i] && done_cnt == 1) begin
            tx_din = ddin;
            trig   = 1'b1;
         end
      end
   endtask

   // scoreboard model: expected line level per sample
   task automatic push_frame(input logic [7:0] din, input int db, input int pe, input int po,
                             input int sb, input int cpb);
      logic par;
      par = (po != 0);
      for (int c = 0; c < cpb; c++) exp_q.push_back(1'b0);
      for (int k = 0; k < db; k++) begin
         par = par ^ din[k];
         for (int c = 0; c < cpb; c++) exp_q.push_back(din[k]);
      end
      if (pe != 0)
         for (int c = 0; c < cpb; c++) exp_q.push_back(par);
      for (int c = 0; c < sb * cpb; c++) exp_q.push_back(1'b1);
   endtask

   task automatic push_idle(input int n);
      for (int c = 0; c < n; c++) exp_q.push_back(1'b1);
   endtask

   task automatic compare_stream(input string tag);
      int mism;
      int first_bad;
      mism      = 0;
      first_bad = -1;
      for (int i = 0; i < exp_q.size(); i++) begin
         if (cap_ser[i] !== exp_q[i]) begin
            mism++;
            if (first_bad < 0) first_bad = i;
         end
      end
      if (mism != 0) $display("  %s first differing sample %0d", tag, first_bad);
      check_int(tag, mism, 0);
      exp_q.delete();
   endtask

   initial begin
      logic hand_a5 [10];
      hand_a5 = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      rst_n  = 1'b0;
      trig   = 1'b0;
      tx_din = 8'h00;
      sel    = 2'd0;

      // reset state
      repeat (3) @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         check_bit($sformatf("reset_serial_%0d", k), ser_v[k], 1'b1);
         check_bit($sformatf("reset_busy_%0d", k), busy_v[k], 1'b0);
         check_bit($sformatf("reset_done_%0d", k), done_v[k], 1'b0);
      end
      rst_n = 1'b1;
      @(negedge clk);

      // single 0xA5 frame, defaults
      start_frame(2'd0, 8'hA5);
      capture(175, -1, -1, 8'h00, 1'b0, 8'h00);
      check_bit("a5_start_latency", cap_ser[0], 1'b0);
      check_bit("a5_busy_latency", cap_busy[0], 1'b1);
      for (int k = 0; k < 10; k++)
         check_bit($sformatf("a5_bit_%0d", k), cap_ser[k*16+8], hand_a5[k]);
      check_int("a5_busy_cycles", busy_cnt, 160);
      check_int("a5_done_count", done_cnt, 1);
      check_int("a5_done_index", first_done, 160);
      check_bit("a5_busy_low_at_done", cap_busy[160], 1'b0);
      push_frame(8'hA5, 8, 0, 0, 1, 16);
      push_idle(15);
      compare_stream("a5_stream");

      // back-to-back: retrigger in the tx_done cycle
      start_frame(2'd0, 8'h3C);
      capture(340, -1, -1, 8'h00, 1'b1, 8'hC3);
      check_int("b2b_done_count", done_cnt, 2);
      check_int("b2b_busy_cycles", busy_cnt, 320);
      check_int("b2b_first_done", first_done, 160);
      check_bit("b2b_second_done", cap_done[321], 1'b1);
      push_frame(8'h3C, 8, 0, 0, 1, 16);
      push_idle(1);
      push_frame(8'hC3, 8, 0, 0, 1, 16);
      push_idle(19);
      compare_stream("b2b_stream");

      // triggers during a frame are ignored
      start_frame(2'd0, 8'h00);
      capture(175, 60, 150, 8'hFF, 1'b0, 8'h00);
      check_int("busytrig_done_count", done_cnt, 1);
      check_int("busytrig_busy_cycles", busy_cnt, 160);
      push_frame(8'h00, 8, 0, 0, 1, 16);
      push_idle(15);
      compare_stream("busytrig_stream");

      // odd parity, 0x00
      start_frame(2'd1, 8'h00);
      capture(185, -1, -1, 8'h00, 1'b0, 8'h00);
      check_bit("odd_parity_bit", cap_ser[9*16+8], 1'b1);
      check_int("odd_busy_cycles", busy_cnt, 176);
      check_int("odd_done_index", first_done, 176);
      push_frame(8'h00, 8, 1, 1, 1, 16);
      push_idle(9);
      compare_stream("odd_stream");

      // even parity, 0x07
      start_frame(2'd2, 8'h07);
      capture(185, -1, -1, 8'h00, 1'b0, 8'h00);
      check_bit("even_parity_bit", cap_ser[9*16+8], 1'b1);
      check_int("even_busy_cycles", busy_cnt, 176);
      check_int("even_done_count", done_cnt, 1);
      push_frame(8'h07, 8, 1, 0, 1, 16);
      push_idle(9);
      compare_stream("even_stream");

      // asynchronous reset during data bit 4 (0xEF has bit 4 low)
      start_frame(2'd0, 8'hEF);
      capture(88, -1, -1, 8'h00, 1'b0, 8'h00);
      check_bit("rst_pre_serial", cap_ser[87], 1'b0);
      #2 rst_n = 1'b0;
      #1;
      check_bit("rst_async_serial", ser_v[0], 1'b1);
      check_bit("rst_async_busy", busy_v[0], 1'b0);
      capture(3, -1, -1, 8'h00, 1'b0, 8'h00);
      check_int("rst_hold_done", done_cnt, 0);
      check_int("rst_hold_busy", busy_cnt, 0);
      rst_n = 1'b1;
      capture(20, -1, -1, 8'h00, 1'b0, 8'h00);
      check_int("rst_after_done", done_cnt, 0);
      start_frame(2'd0, 8'h96);
      capture(170, -1, -1, 8'h00, 1'b0, 8'h00);
      check_int("rst_clean_done", done_cnt, 1);
      check_int("rst_clean_busy", busy_cnt, 160);
      push_frame(8'h96, 8, 0, 0, 1, 16);
      push_idle(10);
      compare_stream("rst_clean_stream");

      // 7 data bits, 2 stop bits, 4 clks/bit
      start_frame(2'd3, 8'hFF);
      capture(50, -1, -1, 8'h00, 1'b0, 8'h00);
      check_int("short_busy_cycles", busy_cnt, 40);
      check_int("short_done_index", first_done, 40);
      push_frame(8'hFF, 7, 0, 0, 2, 4);
      push_idle(10);
      compare_stream("short_ff_stream");

      start_frame(2'd3, 8'hAA);
      capture(50, -1, -1, 8'h00, 1'b0, 8'h00);
      check_bit("short_bit6", cap_ser[7*4+2], 1'b0);
      check_bit("short_stop_not_bit7", cap_ser[8*4+2], 1'b1);
      check_int("short_aa_done", done_cnt, 1);
      push_frame(8'hAA, 7, 0, 0, 2, 4);
      push_idle(10);
      compare_stream("short_aa_stream");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_tx_core.md
Name: uart_tx_core

Overview:
- UART transmitter DUT that the testbench's driver-side interface stimulates: consumes tx_din/tx_trigger and produces tx_busy/tx_done plus the serial line.
- Serialises one byte per trigger as an asynchronous frame: start, data LSB-first, optional parity, stop bit(s).
- Its serial output is the line fed to the loopback receiver that produces rx_dout/rx_comp.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per serial bit; legal range 2..65535.
- DATA_BITS, 8, data bits per frame; legal range 5..8. tx_din bits above DATA_BITS-1 are ignored.
- PARITY_EN, 0, 1 inserts a parity bit after the data bits.
- PARITY_ODD, 0, 1 selects odd parity, 0 selects even. Only meaningful when PARITY_EN=1.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- tx_din  input  8  byte to transmit; sampled only on an accepted trigger.
- tx_trigger  input  1  start request, level-sampled on posedge clk.
- tx_busy  output  1  high while a frame is in flight.
- tx_done  output  1  single-cycle pulse at the end of a frame.
- tx_serial  output  1  serial line; idle high.

Behaviour:
- Reset: asynchronous on rst_n low, regardless of state. tx_serial=1, tx_busy=0, tx_done=0, FSM=IDLE, all counters=0. Reset mid-frame abandons the frame with no tx_done.
- All outputs are registered.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - tx_trigger=1 at a posedge latches tx_din into the shift register and computes parity.
  - On that same edge: go to START, tx_busy=1, tx_serial=0.
- Bit timing: each state holds tx_serial for exactly CLKS_PER_BIT cycles, timed by a baud counter that counts 0..CLKS_PER_BIT-1 and is cleared on every state entry.
- START -> DATA.
- DATA:
  - Drives shreg[0]; the register shifts right at the end of each bit.
  - A bit counter counts 0..DATA_BITS-1.
  - On the last bit, go to PARITY if PARITY_EN=1, else to STOP.
- Parity bit value: XOR of the data bits, inverted when PARITY_ODD=1.
- PARITY -> STOP.
- STOP:
  - tx_serial=1 for STOP_BITS*CLKS_PER_BIT cycles.
  - On the final edge: go to IDLE, tx_busy=0, tx_done=1 for exactly one cycle.
- Frame length: F = (1+DATA_BITS+PARITY_EN+STOP_BITS)*CLKS_PER_BIT cycles. tx_busy is high for exactly F cycles per frame.
- Latency: trigger sampled at edge N gives start-bit falling edge and tx_busy rise at edge N, and the tx_done pulse at edge N+F.
- Triggers while tx_busy=1 are ignored; there is no queueing.
- Trigger in the tx_done cycle (FSM already IDLE) is accepted. The next start bit begins one cycle later, so frames are spaced by at most one idle cycle.
- tx_din changes after acceptance have no effect on the current frame.
- Trigger held high continuously: a new frame starts each time IDLE is reached.

Decomposition:
- Package uart_pkg holds:
  - typedef enum logic [2:0] tx_state_t {IDLE, START, DATA, PARITY, STOP};
  - the default constants;
  - function frame_cycles() computing F.
- Sub-module uart_baud_gen, sized with $clog2(CLKS_PER_BIT). Inputs clk, rst_n, clear, enable; output bit_end (asserted when count=CLKS_PER_BIT-1). The receiver reuses the same sub-module.

Test Plan:
- Defaults, tx_din=0xA5, one-cycle trigger -> tx_serial per 16-cycle bit: 0,1,0,1,0,0,1,0,1,1. tx_busy high exactly 160 cycles; one tx_done pulse on the cycle tx_busy falls.
- Back-to-back: 0x3C, then a trigger in the tx_done cycle with 0xC3 -> both frames are bit-exact with at most 1 idle-high cycle between them; 2 tx_done pulses total.
- Trigger pulses during a frame (mid-data and during the stop bit) with tx_din=0xFF -> ignored. The current 0x00 frame is unaltered and exactly one tx_done is seen.
- PARITY_EN=1, PARITY_ODD=1, tx_din=0x00 -> parity bit 1. With PARITY_ODD=0 and tx_din=0x07 -> parity bit 1. F=176 cycles.
- rst_n low for 3 cycles during data bit 4 -> tx_serial=1 and tx_busy=0 immediately (asynchronous). No tx_done; the next trigger sends a clean full frame.
- STOP_BITS=2, DATA_BITS=7, CLKS_PER_BIT=4, tx_din=0xFF -> bit 7 is not sent, stop high for 8 cycles, tx_busy high exactly 40 cycles.
